pipeline_mem_access: RTL and testbench

- Memory-access and MEM/WB stage of the RV32I 5-stage pipeline. It consumes the M-stage signals registered by the EX/MEM stage.
- Drives the data-memory bus through a req/gnt/rvalid handshake, aligns store data and byte enables, and sign/zero-extends load data.
- Selects the writeback result and registers it into the W stage.
- Raises o_stall while a bus access is outstanding, so the hazard unit holds the upstream stages.

---
 rtl/pipeline_mem_access.sv | 151 +++++++++++++++
 tb/tb_pipeline_mem_access.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_mem_access.sv
// Memory-access and MEM/WB stage: data-bus handshake, store lane alignment, load extension, W register.
// Optional MISALIGN_TRAP_EN: flags misaligned half/word accesses instead of issuing them.
module pipeline_mem_access #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_ctrl_reg_wr_enM,
  input  logic [1:0]      i_ctrl_result_srcM,
  input  logic            i_ctrl_mem_wr_enM,
  input  logic [3:0]      i_ctrl_mem_byte_selM,
  input  logic            i_ctrl_load_unsignedM,
  input  logic [XLEN-1:0] i_alu_resultM,
  input  logic [XLEN-1:0] i_mem_writedataM,
  input  logic [4:0]      i_regfile_rd_addrM,
  input  logic [XLEN-1:0] i_PCPlus4M,
  input  logic [XLEN-1:0] i_PCTargetM,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_stall,
  output logic            o_ctrl_reg_wr_enW,
`ifdef MISALIGN_TRAP_EN
  output logic            o_misalignedW,
`endif
  output logic [4:0]      o_regfile_rd_addrW,
  output logic [XLEN-1:0] o_resultW
);

  typedef enum logic {S_IDLE, S_WAIT_R} state_e;

  state_e          state_q, state_d;
  logic            is_load, is_store, is_word, is_half, misaligned, access;
  logic [1:0]      off;
  logic            stall, req;
  logic [XLEN-1:0] rdata_sh, load_ext, result_mux;
  logic            reg_wr_en_q, reg_wr_en_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] result_q, result_d;

  always_comb begin
    is_load  = (i_ctrl_result_srcM == 2'b01);
    is_store = i_ctrl_mem_wr_enM;
    is_word  = i_ctrl_mem_byte_selM[3];
    is_half  = i_ctrl_mem_byte_selM[1] & ~i_ctrl_mem_byte_selM[3];
    if (is_word)      off = 2'b00;
    else if (is_half) off = {i_alu_resultM[1], 1'b0};
    else              off = i_alu_resultM[1:0];
    misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misaligned = (is_half & i_alu_resultM[0]) | (is_word & (|i_alu_resultM[1:0]));
`endif
    access = (is_load | is_store) & ~misaligned;
  end

  assign o_dmem_we    = is_store;
  assign o_dmem_addr  = {i_alu_resultM[XLEN-1:2], 2'b00};
  assign o_dmem_be    = i_ctrl_mem_byte_selM << off;
  assign o_dmem_wdata = i_mem_writedataM << {off, 3'b000};

  always_comb begin
    rdata_sh = i_dmem_rdata >> {off, 3'b000};
    if (is_word)
      load_ext = i_dmem_rdata;
    else if (is_half)
      load_ext = {{(XLEN-16){rdata_sh[15] & ~i_ctrl_load_unsignedM}}, rdata_sh[15:0]};
    else
      load_ext = {{(XLEN-8){rdata_sh[7] & ~i_ctrl_load_unsignedM}}, rdata_sh[7:0]};
  end

  // Loads always stall at least once: the data arrives no earlier than the cycle after gnt.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    req     = 1'b0;
    case (state_q)
      S_IDLE: begin
        req = access;
        if (access) begin
          if (!i_dmem_gnt) begin
            stall = 1'b1;
          end else if (is_load) begin
            stall   = 1'b1;
            state_d = S_WAIT_R;
          end
        end
      end
      S_WAIT_R: begin
        if (i_dmem_rvalid) state_d = S_IDLE;
        else               stall   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_stall    = stall & i_rstn;
  assign o_dmem_req = req & i_rstn;

  always_comb begin
    case (i_ctrl_result_srcM)
      2'b00:   result_mux = i_alu_resultM;
      2'b01:   result_mux = load_ext;
      2'b10:   result_mux = i_PCPlus4M;
      default: result_mux = i_PCTargetM;
    endcase
    reg_wr_en_d = 1'b0;
    rd_addr_d   = rd_addr_q;
    result_d    = result_q;
    if (!stall) begin
      reg_wr_en_d = i_ctrl_reg_wr_enM & ~misaligned;
      rd_addr_d   = i_regfile_rd_addrM;
      result_d    = result_mux;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      reg_wr_en_q <= 1'b0;
      rd_addr_q   <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      reg_wr_en_q <= reg_wr_en_d;
      rd_addr_q   <= rd_addr_d;
      result_q    <= result_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;
  assign misaligned_d = misaligned & ~stall;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) misaligned_q <= 1'b0;
    else         misaligned_q <= misaligned_d;
  end

  assign o_misalignedW = misaligned_q;
`endif

  assign o_ctrl_reg_wr_enW  = reg_wr_en_q;
  assign o_regfile_rd_addrW = rd_addr_q;
  assign o_resultW          = result_q;

endmodule

// File: tb/tb_pipeline_mem_access.sv
// Scoreboard bench for pipeline_mem_access: expected bus transfers and W writes are queued
// by the stimulus and popped by a negedge monitor.
module tb_pipeline_mem_access;

  logic        clk, rstn;
  logic        reg_wr_enM, mem_wr_enM, load_unsM;
  logic [1:0]  result_srcM;
  logic [3:0]  byte_selM;
  logic [31:0] alu_resultM, writedataM, pc4M, pctM;
  logic [4:0]  rd_addrM;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, reg_wr_enW;
  logic [4:0]  rd_addrW;
  logic [31:0] resultW;
`ifdef MISALIGN_TRAP_EN
  logic        misalignedW;
`endif

  pipeline_mem_access #(.XLEN(32)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_ctrl_reg_wr_enM(reg_wr_enM), .i_ctrl_result_srcM(result_srcM),
    .i_ctrl_mem_wr_enM(mem_wr_enM), .i_ctrl_mem_byte_selM(byte_selM),
    .i_ctrl_load_unsignedM(load_unsM), .i_alu_resultM(alu_resultM),
    .i_mem_writedataM(writedataM), .i_regfile_rd_addrM(rd_addrM),
    .i_PCPlus4M(pc4M), .i_PCTargetM(pctM),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_be(dmem_be), .o_dmem_wdata(dmem_wdata),
    .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_stall(stall), .o_ctrl_reg_wr_enW(reg_wr_enW),
`ifdef MISALIGN_TRAP_EN
    .o_misalignedW(misalignedW),
`endif
    .o_regfile_rd_addrW(rd_addrW), .o_resultW(resultW)
  );

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;
  typedef struct { logic [4:0] rd; logic [31:0] res; } wb_t;
  bus_t bus_q[$];
  wb_t  wb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
    bus_t b;
    b.we = we; b.addr = addr; b.be = be; b.wdata = wdata;
    bus_q.push_back(b);
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] res);
    wb_t w;
    w.rd = rd; w.res = res;
    wb_q.push_back(w);
  endtask

  // Monitor: every granted request and every W write must match the head of its queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (dmem_req && dmem_gnt) begin
        if (bus_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL bus_unexpected: actual addr=%h be=%h required no request", dmem_addr, dmem_be);
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          check("bus_we", {31'd0, dmem_we}, {31'd0, b.we});
          check("bus_addr", dmem_addr, b.addr);
          check("bus_be", {28'd0, dmem_be}, {28'd0, b.be});
          check("bus_wdata", dmem_wdata, b.wdata);
        end
      end
      if (reg_wr_enW) begin
        if (wb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wb_unexpected: actual rd=%0d result=%h required no write", rd_addrW, resultW);
        end else begin
          wb_t w;
          w = wb_q.pop_front();
          check("wb_rd", {27'd0, rd_addrW}, {27'd0, w.rd});
          check("wb_result", resultW, w.res);
        end
      end
    end
  end

  task automatic bubble();
    reg_wr_enM = 1'b0; result_srcM = 2'b00; mem_wr_enM = 1'b0; byte_selM = 4'h0;
    load_unsM = 1'b0; alu_resultM = '0; writedataM = '0; rd_addrM = '0;
    pc4M = '0; pctM = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
  endtask

  // Called at posedge+1; holds the op in M until the stage stops stalling.
  task automatic do_op(input string name, input logic [1:0] src, input logic we,
                       input logic [3:0] bsel, input logic uns, input logic rwe,
                       input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdata, input logic [31:0] pc4, input logic [31:0] pct,
                       input int gd, input int rdly, input int exp_stalls);
    int  cyc = 0;
    int  stalls = 0;
    bit  done = 0;
    logic is_ld;
    logic is_acc;
    is_ld  = (src == 2'b01);
    is_acc = is_ld | we;
    reg_wr_enM = rwe; result_srcM = src; mem_wr_enM = we; byte_selM = bsel;
    load_unsM = uns; alu_resultM = addr; writedataM = wd; rd_addrM = rd;
    pc4M = pc4; pctM = pct; dmem_rdata = rdata;
    while (!done && cyc < 20) begin
      dmem_gnt    = is_acc && (cyc == gd);
      dmem_rvalid = is_ld && (cyc == gd + 1 + rdly);
      @(negedge clk);
      if (stall) stalls++;
      else       done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: actual stall still high required release within 20 cycles", name);
    end
    check({name, "_stalls"}, stalls, exp_stalls);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual simulation time limit reached required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bubble();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_wren", {31'd0, reg_wr_enW}, 32'd0);
    check("rst_rd", {27'd0, rd_addrW}, 32'd0);
    check("rst_result", resultW, 32'd0);
    @(posedge clk); #1;

    expect_bus(1'b0, 32'h100, 4'hF, 32'h0); expect_wb(5'd5, 32'hDEADBEEF);
    do_op("lw", 2'b01, 1'b0, 4'hF, 1'b0, 1'b1, 5'd5, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0, 1);
    expect_bus(1'b0, 32'h100, 4'h8, 32'h0); expect_wb(5'd6, 32'hFFFFFF80);
    do_op("lb", 2'b01, 1'b0, 4'h1, 1'b0, 1'b1, 5'd6, 32'h103, 32'h0, 32'h80000000, 0, 0, 0, 0, 1);
    expect_bus(1'b0, 32'h100, 4'h8, 32'h0); expect_wb(5'd7, 32'h00000080);
    do_op("lbu", 2'b01, 1'b0, 4'h1, 1'b1, 1'b1, 5'd7, 32'h103, 32'h0, 32'h80000000, 0, 0, 0, 0, 1);
    expect_bus(1'b1, 32'h100, 4'hC, 32'h12340000);
    do_op("sh", 2'b00, 1'b1, 4'h3, 1'b0, 1'b0, 5'd0, 32'h102, 32'h00001234, 32'h0, 0, 0, 2, 0, 2);
    expect_wb(5'd8, 32'h2004);
    do_op("pc4", 2'b10, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h40, 32'h0, 32'h0, 32'h2004, 32'h0, 0, 0, 0);
    expect_wb(5'd9, 32'h55AA);
    do_op("alu", 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h55AA, 32'h0, 32'h0, 32'h4, 32'h8, 0, 0, 0);
    expect_wb(5'd10, 32'h80001000);
    do_op("pct", 2'b11, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10, 32'h77, 32'h0, 32'h0, 32'h4, 32'h80001000, 0, 0, 0);
    expect_bus(1'b0, 32'h100, 4'hC, 32'h0); expect_wb(5'd11, 32'hFFFF8001);
    do_op("lh", 2'b01, 1'b0, 4'h3, 1'b0, 1'b1, 5'd11, 32'h102, 32'h0, 32'h80010000, 0, 0, 1, 1, 3);
    expect_bus(1'b0, 32'h100, 4'hC, 32'h0); expect_wb(5'd12, 32'h00008001);
    do_op("lhu", 2'b01, 1'b0, 4'h3, 1'b1, 1'b1, 5'd12, 32'h102, 32'h0, 32'h80010000, 0, 0, 0, 0, 1);
    expect_bus(1'b1, 32'h100, 4'h2, 32'h0000AB00);
    do_op("sb", 2'b00, 1'b1, 4'h1, 1'b0, 1'b0, 5'd0, 32'h101, 32'h000000AB, 32'h0, 0, 0, 0, 0, 0);
    expect_bus(1'b1, 32'h104, 4'hF, 32'h11223344);
    do_op("sw", 2'b00, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h104, 32'h11223344, 32'h0, 0, 0, 1, 0, 1);
    expect_bus(1'b0, 32'h10C, 4'hF, 32'h0); expect_wb(5'd13, 32'hCAFEF00D);
    do_op("lw_slow", 2'b01, 1'b0, 4'hF, 1'b0, 1'b1, 5'd13, 32'h10C, 32'h0, 32'hCAFEF00D, 0, 0, 0, 2, 3);
    bubble();
    @(posedge clk); #1;

    // Reset while waiting for read data: the transaction is dropped.
    expect_bus(1'b0, 32'h200, 4'hF, 32'h0);
    reg_wr_enM = 1'b1; result_srcM = 2'b01; byte_selM = 4'hF; alu_resultM = 32'h200;
    rd_addrM = 5'd14; dmem_rdata = 32'h13579BDF; dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    #1 check("wait_r_stall", {31'd0, stall}, 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_req", {31'd0, dmem_req}, 32'd0);
    check("mid_rst_wren", {31'd0, reg_wr_enW}, 32'd0);
    check("mid_rst_rd", {27'd0, rd_addrW}, 32'd0);
    check("mid_rst_result", resultW, 32'd0);
    bubble();
    dmem_rdata = 32'h13579BDF;
    @(posedge clk); #1 dmem_rvalid = 1'b1;
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1 dmem_rvalid = 1'b0;
    @(posedge clk); #1;
    check("late_rvalid_wren", {31'd0, reg_wr_enW}, 32'd0);
    check("late_rvalid_result", resultW, 32'd0);

`ifdef MISALIGN_TRAP_EN
    reg_wr_enM = 1'b1; result_srcM = 2'b01; byte_selM = 4'hF; alu_resultM = 32'h101;
    rd_addrM = 5'd15; dmem_gnt = 1'b1;
    @(negedge clk);
    check("mis_req", {31'd0, dmem_req}, 32'd0);
    check("mis_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    bubble();
    check("mis_flag", {31'd0, misalignedW}, 32'd1);
    check("mis_wren", {31'd0, reg_wr_enW}, 32'd0);
    @(posedge clk); #1;
    check("mis_flag_clear", {31'd0, misalignedW}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("wb_q_drained", wb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
